ikari_pixel_serializer: RTL
===========================

IKARI_PIXEL_SERIALIZER -- requirements
Module: ikari_pixel_serializer

Interface
REQ-001 SHALL use reset Reset_n, synchronous, active-low, on clock clk; all state changes occur on posedge clk.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- Cen  in  1  pixel clock enable, single-cycle strobe
- PLOAD_RSHIFTn  in  1  0 = load shift register, 1 = shift
- RL_Sel  in  1  1 = shift out LSB nibble first, 0 = MSB nibble first
- VLK  in  1  1 = latch color attribute on Cen
- AB_Sel  in  1  line-buffer bank select: 0 = write A / read B, 1 = write B / read A
- rom_data  in  32  8 pixels at 4 bpp, pixel 0 = bits 3:0
- attr_color  in  4  palette bank for the current object
- wr_x_load  in  1  load write X pointer (qualified by Cen)
- wr_x  in  8  write X start position
- rd_x  in  8  read X position of the display beam
- pix_out  out  8  {color, index} read from display bank
- busy  out  1  shift register holds unsent pixels

Function
REQ-003 SHALL act only on cycles with Cen=1, except reset; with Cen=0 all registers hold.
REQ-004 SHALL contain shift register sr[31:0], pixel counter cnt[3:0] (0..8), color latch col[3:0], write pointer wx[7:0], write-bank latch wb, and two 256x8 line buffers A and B.
REQ-005 Load: SHALL set sr=rom_data, cnt=8, wb=AB_Sel, dir=RL_Sel when Cen=1 and PLOAD_RSHIFTn=0; SHALL perform no buffer write on that cycle.
REQ-006 Shift: when Cen=1, PLOAD_RSHIFTn=1 and cnt>0, SHALL emit nibble p = sr[3:0] if dir=1, else sr[31:28]; SHALL shift sr by 4 toward the emitted end, zero-filling; SHALL decrement cnt.
REQ-007 SHALL write {col,p} to bank wb at address wx when p!=0; p=0 is transparent, with no write.
REQ-008 SHALL increment wx mod 256 on every shift cycle, transparent or not; 255 wraps to 0.
REQ-009 When cnt=0, shift cycles SHALL not write and SHALL not advance wx.
REQ-010 Load during a group (cnt>0) SHALL discard the remaining pixels; load takes priority.
REQ-011 wr_x_load with Cen SHALL set wx=wr_x; if the same Cen is also a shift, SHALL write that pixel at wr_x and leave wx=wr_x+1.
REQ-012 VLK with Cen SHALL set col=attr_color; the new color applies to pixels emitted from the next Cen onward.
REQ-013 AB_Sel changes during a group SHALL NOT redirect that group; wb stays latched until the next load.
REQ-014 Read: each Cen SHALL register pix_out = read bank[rd_x], with 1-Cen latency, read bank = B if AB_Sel=0 else A.
REQ-015 SHALL clear read bank[rd_x] to 0 on the same Cen it is read (clear-after-read).
REQ-016 When read and write target the same bank and address in one cycle (AB_Sel toggled mid-group), the write SHALL win and pix_out SHALL show the pre-write value.
REQ-017 busy SHALL equal (cnt!=0), combinational from the register.
REQ-018 Line buffers SHALL infer synchronous single-clock RAM: one write port plus one read/clear port per bank.

Reset
REQ-019 Reset_n=0 SHALL clear sr, cnt, col, wx, wb, dir and pix_out to 0; busy=0 follows.
REQ-020 Reset SHALL NOT clear line-buffer contents; the first displayed line after reset is don't-care.
REQ-021 Reset mid-group SHALL abort the group; no further writes occur until the next load.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Load rom_data=0x87654321, RL_Sel=1, col=5, wx=0x10, AB_Sel=0, then 8 shifts -> A[0x10..0x17] = 0x51..0x58, busy falls after the 8th shift.
- Same data with RL_Sel=0 -> A[0x10..0x17] = 0x58..0x51.
- rom_data=0x00F000F0, wx=0xFC, RL_Sel=1 -> writes only A[0xFD]=col:F and A[0x01]=col:F, wx wraps to 0x04.
- Toggle AB_Sel after 3 shifts -> all 8 pixels land in A; reading B with rd_x returns old data and clears it to 0; a second read returns 0x00.
- Reload after 4 shifts -> 4 pixels written, cnt=8, no write on the load cycle.
- Assert Reset_n=0 at the 2nd shift -> cnt=0, pix_out=0, no further writes.

Source files
------------

// File: rtl/ikari_pixel_serializer_if.sv
// Pixel serializer bus: load/shift control, ROM data,
// line-buffer addressing and display output.
interface ikari_pixel_serializer_if;
  logic        Cen;
  logic        PLOAD_RSHIFTn;
  logic        RL_Sel;
  logic        VLK;
  logic        AB_Sel;
  logic [31:0] rom_data;
  logic [3:0]  attr_color;
  logic        wr_x_load;
  logic [7:0]  wr_x;
  logic [7:0]  rd_x;
  logic [7:0]  pix_out;
  logic        busy;

  modport master (
    output Cen, PLOAD_RSHIFTn, RL_Sel, VLK, AB_Sel,
    output rom_data, attr_color, wr_x_load, wr_x, rd_x,
    input  pix_out, busy
  );

  modport slave (
    input  Cen, PLOAD_RSHIFTn, RL_Sel, VLK, AB_Sel,
    input  rom_data, attr_color, wr_x_load, wr_x, rd_x,
    output pix_out, busy
  );
endinterface

// File: rtl/ikari_pixel_serializer.sv
// 4bpp object serializer into ping-pong line buffers
// with clear-after-read display port.
module ikari_pixel_serializer (
  input  logic clk,
  input  logic Reset_n,
  ikari_pixel_serializer_if.slave bus
);

  logic [31:0] sr;
  logic [3:0]  cnt;
  logic [3:0]  col;
  logic [7:0]  wx;
  logic        wb;
  logic        dir;

  logic [7:0]  buf_a [256];
  logic [7:0]  buf_b [256];
  logic [7:0]  dout_a;
  logic [7:0]  dout_b;
  logic        rsel;
  logic        pix_vld;

  logic        shift;
  logic [3:0]  p;
  logic [7:0]  wa;
  logic [7:0]  wd;
  logic        we_a;
  logic        we_b;
  logic        clr_a;
  logic        clr_b;

  // Shift decode, emitted nibble and write-port controls.
  always_comb begin
    shift = bus.Cen & bus.PLOAD_RSHIFTn & (cnt != 4'd0);
    p     = dir ? sr[3:0] : sr[31:28];
    wa    = bus.wr_x_load ? bus.wr_x : wx;
    wd    = {col, p};
    we_a  = shift & (p != 4'd0) & ~wb;
    we_b  = shift & (p != 4'd0) & wb;
    clr_a = bus.Cen & bus.AB_Sel;
    clr_b = bus.Cen & ~bus.AB_Sel;
  end

  // Shift register, counter, color, pointer and bank latch.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      sr  <= '0;
      cnt <= '0;
      col <= '0;
      wx  <= '0;
      wb  <= 1'b0;
      dir <= 1'b0;
    end else if (bus.Cen) begin
      if (bus.VLK)
        col <= bus.attr_color;
      if (!bus.PLOAD_RSHIFTn) begin
        sr  <= bus.rom_data;
        cnt <= 4'd8;
        wb  <= bus.AB_Sel;
        dir <= bus.RL_Sel;
        wx  <= wa;
      end else if (shift) begin
        sr  <= dir ? {4'h0, sr[31:4]} : {sr[27:0], 4'h0};
        cnt <= cnt - 4'd1;
        wx  <= wa + 8'd1;
      end else begin
        wx  <= wa;
      end
    end
  end

  // Bank A: registered read, clear-after-read; pixel write wins.
  always_ff @(posedge clk) begin
    if (Reset_n && bus.Cen) begin
      dout_a <= buf_a[bus.rd_x];
      if (clr_a)
        buf_a[bus.rd_x] <= 8'h00;
      if (we_a)
        buf_a[wa] <= wd;
    end
  end

  // Bank B: registered read, clear-after-read; pixel write wins.
  always_ff @(posedge clk) begin
    if (Reset_n && bus.Cen) begin
      dout_b <= buf_b[bus.rd_x];
      if (clr_b)
        buf_b[bus.rd_x] <= 8'h00;
      if (we_b)
        buf_b[wa] <= wd;
    end
  end

  // Output bank select and reset mask for the read data.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      rsel    <= 1'b0;
      pix_vld <= 1'b0;
    end else if (bus.Cen) begin
      rsel    <= bus.AB_Sel;
      pix_vld <= 1'b1;
    end
  end

  assign bus.pix_out = pix_vld ? (rsel ? dout_a : dout_b) : 8'h00;
  assign bus.busy    = (cnt != 4'd0);

endmodule
